// File: rtl/controlador_vedacao_pkg.sv
// Shared types and constants for the bottle-capping station sequencer.
package controlador_vedacao_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ESTEIRA    = 3'd1,
        VEDANDO    = 3'd2,
        SAIDA      = 3'd3,
        REABASTECE = 3'd4
    } estado_t;

    // Packed {dezenas, unidades} value meaning an empty tray.
    localparam logic [2*BCD_W-1:0] ESTOQUE_ZERO = '0;

    // Binary 0..99 to packed two-digit BCD; used on elaboration-time constants.
    function automatic logic [2*BCD_W-1:0] para_bcd(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

endpackage

// File: rtl/controlador_vedacao_estoque.sv
// Two-digit BCD cork-stock down-counter with load, zero saturation and compares.
module estoque_bcd
    import controlador_vedacao_pkg::*;
#(
    parameter int CAPACIDADE = 20,
    parameter int LIMIAR_CR  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carregar_i,
    input  logic             decrementar_i,
    output logic [BCD_W-1:0] unidades_o,
    output logic [BCD_W-1:0] dezenas_o,
    output logic             cr_o,
    output logic             bz_o,
    output logic             baixo_o
);

    localparam logic [2*BCD_W-1:0] CAP_BCD = para_bcd(CAPACIDADE);
    localparam logic [2*BCD_W-1:0] LIM_BCD = para_bcd(LIMIAR_CR);

    logic [BCD_W-1:0] uni_q, uni_d;
    logic [BCD_W-1:0] dez_q, dez_d;
    logic [2*BCD_W-1:0] estoque;

    assign estoque = {dez_q, uni_q};

    // Next stock: load wins over decrement; decrement saturates at 00.
    always_comb begin
        uni_d = uni_q;
        dez_d = dez_q;
        if (carregar_i) begin
            dez_d = CAP_BCD[2*BCD_W-1:BCD_W];
            uni_d = CAP_BCD[BCD_W-1:0];
        end else if (decrementar_i && estoque != ESTOQUE_ZERO) begin
            if (uni_q == '0) begin
                uni_d = BCD_W'(9);
                dez_d = dez_q - 1'b1;
            end else begin
                uni_d = uni_q - 1'b1;
            end
        end
    end

    // Stock register, reloaded to full capacity on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dez_q <= CAP_BCD[2*BCD_W-1:BCD_W];
            uni_q <= CAP_BCD[BCD_W-1:0];
        end else begin
            dez_q <= dez_d;
            uni_q <= uni_d;
        end
    end

    // Packed BCD compares in the same order as the binary value.
    assign cr_o       = (estoque == LIM_BCD);
    assign bz_o       = (estoque == ESTOQUE_ZERO);
    assign baixo_o    = (estoque <= LIM_BCD) && !bz_o;
    assign unidades_o = uni_q;
    assign dezenas_o  = dez_q;

endmodule

// File: rtl/controlador_vedacao.sv
// Capping-station sequencer: conveyor/capper FSM, cap timer, feeder handshake, timeout alarm.
module controlador_vedacao
    import controlador_vedacao_pkg::*;
#(
    parameter int CAPACIDADE  = 20,
    parameter int LIMIAR_CR   = 5,
    parameter int CICLOS_VEDA = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             liga,
    input  logic             garrafa_pos,
    input  logic             ack_reabastecer,
    output logic             motor_esteira,
    output logic             vedar,
    output logic             req_reabastecer,
    output logic             CR,
    output logic             BZ,
    output logic             alarme,
    output logic [BCD_W-1:0] unidades_bandeja,
    output logic [BCD_W-1:0] dezenas_bandeja
);

    estado_t    state_q, state_d;
    logic [3:0] tmr_q, tmr_d;
    logic [7:0] tmo_q, tmo_d;
    logic       alarme_q, alarme_d;
    logic       req_q, req_d;
    logic       bloq_q, bloq_d;
    logic       motor_q, motor_d;
    logic       vedar_q, vedar_d;
    logic       aceita, decrementa, quer_req;
    logic       bz, baixo;

    estoque_bcd #(
        .CAPACIDADE (CAPACIDADE),
        .LIMIAR_CR  (LIMIAR_CR)
    ) u_estoque (
        .clk           (clk),
        .reset         (reset),
        .carregar_i    (aceita),
        .decrementar_i (decrementa),
        .unidades_o    (unidades_bandeja),
        .dezenas_o     (dezenas_bandeja),
        .cr_o          (CR),
        .bz_o          (bz),
        .baixo_o       (baixo)
    );

    // Ack is taken only while requesting, after ack was seen low, and never during a cap
    // so a reload cannot coincide with the decrement.
    assign aceita = req_q && ack_reabastecer && !bloq_q && (state_q != VEDANDO);

    // Next state, cap timer, feeder timeout and handshake; Moore outputs come from state_d.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        decrementa = 1'b0;
        case (state_q)
            IDLE: begin
                if (liga) state_d = (bz && !aceita) ? REABASTECE : ESTEIRA;
            end
            ESTEIRA: begin
                if (garrafa_pos) begin
                    state_d = VEDANDO;
                    tmr_d   = 4'(CICLOS_VEDA - 1);
                end else if (!liga) begin
                    state_d = IDLE;
                end
            end
            VEDANDO: begin
                if (tmr_q == '0) begin
                    decrementa = 1'b1;
                    state_d    = SAIDA;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SAIDA: begin
                if (!garrafa_pos) begin
                    if (bz && !aceita) state_d = REABASTECE;
                    else if (!liga)    state_d = IDLE;
                    else               state_d = ESTEIRA;
                end
            end
            REABASTECE: begin
                if (aceita) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timeout runs only while the tray is empty and waiting on the feeder.
        tmo_d = '0;
        if (state_q == REABASTECE && bz && !aceita)
            tmo_d = (tmo_q == 8'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
        alarme_d = alarme_q || (state_q == REABASTECE && tmo_d == 8'(TIMEOUT));

        quer_req = (state_d == REABASTECE) ||
                   (baixo && (state_d == IDLE || state_d == ESTEIRA || state_d == SAIDA));
        if (aceita)     req_d = 1'b0;
        else if (req_q) req_d = 1'b1;
        else            req_d = quer_req && !bloq_q;
        bloq_d = aceita || (bloq_q && ack_reabastecer);

        motor_d = (state_d == ESTEIRA) || (state_d == SAIDA);
        vedar_d = (state_d == VEDANDO);
    end

    // State and registered outputs; reset aborts any cap in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            tmo_q    <= '0;
            alarme_q <= 1'b0;
            req_q    <= 1'b0;
            bloq_q   <= 1'b0;
            motor_q  <= 1'b0;
            vedar_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            tmo_q    <= tmo_d;
            alarme_q <= alarme_d;
            req_q    <= req_d;
            bloq_q   <= bloq_d;
            motor_q  <= motor_d;
            vedar_q  <= vedar_d;
        end
    end

    assign motor_esteira   = motor_q;
    assign vedar           = vedar_q;
    assign req_reabastecer = req_q;
    assign alarme          = alarme_q;
    assign BZ              = bz;

endmodule

// File: tb/tb_controlador_vedacao.sv
// Directed bench for the capping-station sequencer.
module tb_controlador_vedacao;

    logic       clk = 1'b0;
    logic       reset, liga, garrafa_pos, ack_reabastecer;
    logic       motor_esteira, vedar, req_reabastecer, CR, BZ, alarme;
    logic [3:0] unidades_bandeja, dezenas_bandeja;

    int n_cmp = 0;
    int n_err = 0;
    int est   = 20;

    controlador_vedacao dut (
        .clk              (clk),
        .reset            (reset),
        .liga             (liga),
        .garrafa_pos      (garrafa_pos),
        .ack_reabastecer  (ack_reabastecer),
        .motor_esteira    (motor_esteira),
        .vedar            (vedar),
        .req_reabastecer  (req_reabastecer),
        .CR               (CR),
        .BZ               (BZ),
        .alarme           (alarme),
        .unidades_bandeja (unidades_bandeja),
        .dezenas_bandeja  (dezenas_bandeja)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_est(input string tag);
        chk({tag, ".dezenas"}, int'(dezenas_bandeja), est / 10);
        chk({tag, ".unidades"}, int'(unidades_bandeja), est % 10);
    endtask

    // One bottle from ESTEIRA through the cap and out of SAIDA.
    task automatic garrafa(input bit ver_pulso);
        int n;
        garrafa_pos = 1'b1;
        tick();
        garrafa_pos = 1'b0;
        n = 0;
        while (vedar && n < 20) begin
            n++;
            tick();
        end
        if (ver_pulso) chk("vedar_ciclos", n, 4);
        if (est > 0) est--;
        tick();
    endtask

    initial begin
        reset = 1'b0; liga = 1'b0; garrafa_pos = 1'b0; ack_reabastecer = 1'b0;
        tick(); tick();

        // Reset state
        chk_est("reset");
        chk("reset.motor", int'(motor_esteira), 0);
        chk("reset.vedar", int'(vedar), 0);
        chk("reset.req", int'(req_reabastecer), 0);
        chk("reset.alarme", int'(alarme), 0);
        chk("reset.CR", int'(CR), 0);
        chk("reset.BZ", int'(BZ), 0);

        // Line start, 15 bottles to stock 05
        reset = 1'b1; liga = 1'b1;
        tick();
        chk("start.motor", int'(motor_esteira), 1);
        for (int i = 0; i < 15; i++) garrafa(i < 3);
        chk_est("b15");
        chk("b15.CR", int'(CR), 1);
        chk("b15.req", int'(req_reabastecer), 1);
        chk("b15.motor", int'(motor_esteira), 1);

        // Run dry, wait in REABASTECE, then refill
        for (int i = 0; i < 5; i++) garrafa(1'b0);
        chk_est("vazio");
        chk("vazio.BZ", int'(BZ), 1);
        chk("vazio.motor", int'(motor_esteira), 0);
        chk("vazio.req", int'(req_reabastecer), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("vazio.alarme", int'(alarme), 0);
        ack_reabastecer = 1'b1;
        tick();
        est = 20;
        chk_est("recarga");
        chk("recarga.req", int'(req_reabastecer), 0);
        chk("recarga.BZ", int'(BZ), 0);
        ack_reabastecer = 1'b0;
        tick();
        chk("recarga.motor", int'(motor_esteira), 1);

        // Back to 05, ack arrives mid-cap and is deferred to SAIDA
        for (int i = 0; i < 15; i++) garrafa(1'b0);
        chk_est("b05");
        chk("b05.req", int'(req_reabastecer), 1);
        garrafa_pos = 1'b1;
        tick();
        garrafa_pos = 1'b0;
        tick();
        ack_reabastecer = 1'b1;
        tick(); tick();
        chk("adiado.vedar", int'(vedar), 1);
        chk_est("adiado.v4");
        tick();
        est = 4;
        chk_est("adiado.saida");
        chk("adiado.saida.vedar", int'(vedar), 0);
        chk("adiado.saida.req", int'(req_reabastecer), 1);
        tick();
        est = 20;
        chk_est("adiado.recarga");
        chk("adiado.recarga.req", int'(req_reabastecer), 0);
        tick(); tick();
        chk_est("adiado.unica");
        chk("adiado.ack_alto.req", int'(req_reabastecer), 0);
        ack_reabastecer = 1'b0;
        tick();
        chk("adiado.ack_baixo.req", int'(req_reabastecer), 0);
        chk("adiado.motor", int'(motor_esteira), 1);

        // Feeder timeout
        for (int i = 0; i < 20; i++) garrafa(1'b0);
        chk_est("tmo.vazio");
        chk("tmo.motor", int'(motor_esteira), 0);
        for (int i = 0; i < 254; i++) tick();
        chk("tmo.254", int'(alarme), 0);
        tick();
        chk("tmo.255", int'(alarme), 1);
        ack_reabastecer = 1'b1;
        tick();
        est = 20;
        chk_est("tmo.recarga");
        chk("tmo.recarga.alarme", int'(alarme), 1);
        ack_reabastecer = 1'b0;
        tick();
        chk("tmo.retoma.motor", int'(motor_esteira), 1);
        chk("tmo.retoma.alarme", int'(alarme), 1);

        // Reset on the second cap cycle
        garrafa(1'b1);
        chk_est("rst.antes");
        garrafa_pos = 1'b1;
        tick();
        garrafa_pos = 1'b0;
        tick();
        chk("rst.v2.vedar", int'(vedar), 1);
        reset = 1'b0;
        tick();
        est = 20;
        chk("rst.vedar", int'(vedar), 0);
        chk("rst.motor", int'(motor_esteira), 0);
        chk("rst.alarme", int'(alarme), 0);
        chk_est("rst");
        reset = 1'b1;
        tick();
        chk("rst.retoma.motor", int'(motor_esteira), 1);
        liga = 1'b0;
        tick();
        chk("parada.motor", int'(motor_esteira), 0);
        chk_est("parada");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_vedacao.md
Name: controlador_vedacao

Overview:
Sequencer for the bottle-capping station. It owns the cork-tray stock as a two-digit BCD count and drives the conveyor and the capping actuator. It also runs a req/ack refill handshake with the cork feeder. It sits between the line sensors and the actuators, and exports CR/BZ and the BCD stock digits for the display path.

Parameters:
CAPACIDADE, 20, corks loaded at reset and on refill; must be 1..99.
LIMIAR_CR, 5, stock at or below this raises refill request and CR.
CICLOS_VEDA, 4, clock cycles `vedar` is held per bottle; must be 1..15.
TIMEOUT, 255, cycles spent in REABASTECE with stock 0 before alarm; 8-bit counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
liga  in  1  line enable; 0 = stop at the next safe point
garrafa_pos  in  1  bottle under capping head (level)
ack_reabastecer  in  1  feeder done; stock reloaded on the first cycle it is seen high
motor_esteira  out  1  conveyor run
vedar  out  1  capping actuator drive
req_reabastecer  out  1  refill request
CR  out  1  stock == LIMIAR_CR
BZ  out  1  stock == 0
alarme  out  1  sticky feeder timeout
unidades_bandeja  out  4  BCD units of stock
dezenas_bandeja  out  4  BCD tens of stock

Behaviour:
- All state updates on the rising edge of clk. reset=0 sampled on an edge forces:
  - state IDLE; stock = CAPACIDADE (20 → dezenas=2, unidades=0);
  - all other outputs 0; timer and alarme cleared.
- Reset overrides every other input, including a capping cycle in progress (vedar drops on the next edge).
- Stock is BCD. Decrement: unidades 0 → 9 with dezenas−1, otherwise unidades−1. Never decrements below 00. Refill loads CAPACIDADE; there is no addition.
- CR and BZ are combinational from the stock registers.
- States (registered Moore outputs):
  - IDLE: all actuators off.
    - If liga=1 and stock>0 → ESTEIRA.
    - If liga=1 and stock=0 → REABASTECE.
  - ESTEIRA: motor_esteira=1.
    - garrafa_pos=1 → VEDANDO; the timer loads CICLOS_VEDA−1.
    - liga=0 (with garrafa_pos=0) → IDLE.
  - VEDANDO: motor_esteira=0, vedar=1 for exactly CICLOS_VEDA cycles.
    - On the last cycle, stock decrements by 1 → SAIDA.
  - SAIDA: motor_esteira=1, vedar=0; wait for garrafa_pos=0. Then:
    - stock=0 → REABASTECE;
    - else liga=0 → IDLE;
    - else → ESTEIRA.
  - REABASTECE: motor off; req_reabastecer=1; timer counts cycles while stock=0.
    - ack_reabastecer=1 → stock=CAPACIDADE; req drops on the next cycle; timer cleared → IDLE.
    - Timer reaching TIMEOUT → alarme=1, held until reset. The state stays REABASTECE; a later ack still reloads stock.
- Early refill: if stock ≤ LIMIAR_CR and stock>0, req_reabastecer is also asserted in IDLE/ESTEIRA/SAIDA, and the line keeps running.
  - An ack there reloads stock without a state change.
  - An ack landing in VEDANDO is deferred: req stays high and the reload occurs on the first ack seen outside VEDANDO.
  - The decrement and a reload never happen in the same cycle.
- Handshake rule: once asserted, req stays high until an ack has been accepted. After the ack is accepted, req stays low until ack has been seen low for at least one cycle.
- Timeout is measured only while stock=0 in REABASTECE. alarme never clears except by reset.
- A bottle present when the line enters ESTEIRA is capped immediately on the next cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ESTEIRA, VEDANDO, SAIDA, REABASTECE, 3-bit);
  - BCD digit width (4);
  - the helper constant for stock zero.
- One sub-module is natural: `estoque_bcd`, a two-digit BCD down-counter with synchronous load of CAPACIDADE, decrement enable, zero saturation, and CR/BZ compares.
- The FSM, timers and handshake stay in the top.

Test Plan:
- Reset → stock 20 (dezenas=2, unidades=0); motor, vedar, req and alarme all 0; state IDLE.
- liga=1, then garrafa_pos pulsed 15 times with proper exit → vedar held 4 cycles per bottle; stock 20→05; CR=1 and req_reabastecer=1 after the 15th bottle, with the line still running.
- Continue bottles with no ack → stock decrements to 00, BZ=1 → REABASTECE with motor off; ack after 10 cycles → stock 20, req low the next cycle, line restarts.
- At stock 05, assert ack on the second VEDANDO cycle (held 6 cycles) → the cap completes (stock 04), then the reload to 20 happens once, in SAIDA.
- At stock 00 with no ack for 255 cycles → alarme=1 and it stays high after a later ack (stock reloads to 20); only reset clears it.
- reset=0 on the second VEDANDO cycle → next edge: vedar=0, stock 20, state IDLE, no decrement applied.
